clk2phase_monitor: RTL

- Receive-side checker for the two-phase non-overlapping clock pair (phi1/phi2) produced by the two-phase generator.
- Oversamples phi1/phi2 on a fast free-running clock and checks three things: non-overlap, dead time, and strict phi1→phi2 alternation.
- Measures the high width of each phase and reports sticky error flags, a lock indication and a period counter to the datapath test harness.

---
 rtl/clk2phase_monitor_if.sv | 44 ++++
 rtl/clk2phase_monitor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk2phase_monitor_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk2phase_monitor_if                                          |
// | Purpose  : Bundles the phase inputs, error-clear strobe and status       |
// |            outputs of the two-phase clock monitor.                       |
// | Signals  : phi1, phi2     - phase clocks under test (async to master)    |
// |            clr_err        - synchronous clear of the sticky error flags  |
// |            overlap_err, gap_err, width_err, order_err - sticky flags     |
// |            locked         - enough consecutive clean periods seen        |
// |            period_cnt     - clean-period counter (wraps)                 |
// |            last_w1/last_w2- most recent measured high widths             |
// | Modports : master - drives phases/clear, reads status (test harness)     |
// |            slave  - the monitor itself                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface clk2phase_monitor_if #(
  parameter int CNT_W = 8
);
  logic             phi1;
  logic             phi2;
  logic             clr_err;
  logic             overlap_err;
  logic             gap_err;
  logic             width_err;
  logic             order_err;
  logic             locked;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] last_w1;
  logic [CNT_W-1:0] last_w2;

  modport master (
    output phi1, phi2, clr_err,
    input  overlap_err, gap_err, width_err, order_err, locked,
    input  period_cnt, last_w1, last_w2
  );

  modport slave (
    input  phi1, phi2, clr_err,
    output overlap_err, gap_err, width_err, order_err, locked,
    output period_cnt, last_w1, last_w2
  );
endinterface
`default_nettype wire

// File: rtl/clk2phase_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk2phase_monitor                                             |
// | Purpose  : Oversampling checker for a two-phase non-overlapping clock    |
// |            pair. Checks non-overlap, dead time, phi1->phi2 alternation   |
// |            and high widths; reports sticky flags, lock and period count. |
// | Ports    : master - fast sampling clock (rising edge)                    |
// |            rst    - synchronous active-high reset                        |
// |            bus    - clk2phase_monitor_if.slave (phases, clr_err, status) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clk2phase_monitor #(
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 8,
  parameter int MIN_GAP      = 1,
  parameter int CNT_W        = 8,
  parameter int LOCK_PERIODS = 4
) (
  input  logic               master,
  input  logic               rst,
  clk2phase_monitor_if.slave bus
);

  localparam int LCK_W = $clog2(LOCK_PERIODS + 1);

  localparam logic [CNT_W-1:0] c_min_high = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] c_max_high = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] c_min_gap  = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [LCK_W-1:0] c_lock     = LCK_W'(LOCK_PERIODS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1H  = 3'd1,
    G12  = 3'd2,
    P2H  = 3'd3,
    G21  = 3'd4
  } state_t;

  // Synchronizers: meta*_q is the first flop, s*_q the usable sample,
  // p*_q the previous sample used for edge detection.
  logic meta1_q, meta2_q;
  logic s1_q, s2_q;
  logic p1_q, p2_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] last_w1_q, last_w1_d;
  logic [CNT_W-1:0] last_w2_q, last_w2_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             dirty_q, dirty_d;
  logic             ovl_q, ovl_d;
  logic             gap_q, gap_d;
  logic             wid_q, wid_d;
  logic             ord_q, ord_d;

  logic             rise1, rise2;
  logic [CNT_W-1:0] hi_inc, gap_inc;
  logic             ev_ovl, ev_gap, ev_wid, ev_ord, ev_any;
  logic             period_done;

  assign rise1   = s1_q & ~p1_q;
  assign rise2   = s2_q & ~p2_q;
  assign hi_inc  = (hi_cnt_q  == c_cnt_max) ? hi_cnt_q  : hi_cnt_q  + 1'b1;
  assign gap_inc = (gap_cnt_q == c_cnt_max) ? gap_cnt_q : gap_cnt_q + 1'b1;

  // Phase-tracking FSM and width/gap measurement.
  always_comb begin
    state_d     = state_q;
    hi_cnt_d    = hi_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    last_w1_d   = last_w1_q;
    last_w2_d   = last_w2_q;
    // Both phases high is an overlap and also a zero dead time.
    ev_ovl      = s1_q & s2_q;
    ev_gap      = s1_q & s2_q;
    ev_wid      = 1'b0;
    ev_ord      = 1'b0;
    period_done = 1'b0;

    case (state_q)
      IDLE: begin
        // A lone phi2 rise is ignored until phi1 starts a measurement.
        if (rise1) begin
          state_d  = P1H;
          hi_cnt_d = c_cnt_one;
        end
      end

      P1H: begin
        if (!s1_q) begin
          last_w1_d = hi_cnt_q;
          if ((hi_cnt_q < c_min_high) || (hi_cnt_q > c_max_high)) begin
            ev_wid = 1'b1;
          end
          // phi2 already high when phi1 drops: no dead time at all, hand
          // over straight to phi2's high state starting from this sample.
          if (s2_q) begin
            ev_gap   = 1'b1;
            state_d  = P2H;
            hi_cnt_d = c_cnt_one;
          end else begin
            state_d   = G12;
            gap_cnt_d = c_cnt_one;
          end
        end else begin
          hi_cnt_d = hi_inc;
          // Over-long pulses are flagged while still high.
          if (hi_inc > c_max_high) begin
            ev_wid = 1'b1;
          end
        end
      end

      G12: begin
        if (rise2) begin
          if (gap_cnt_q < c_min_gap) begin
            ev_gap = 1'b1;
          end
          state_d  = P2H;
          hi_cnt_d = c_cnt_one;
        end else if (rise1) begin
          ev_ord   = 1'b1;
          state_d  = P1H;
          hi_cnt_d = c_cnt_one;
        end else begin
          gap_cnt_d = gap_inc;
        end
      end

      P2H: begin
        if (!s2_q) begin
          last_w2_d = hi_cnt_q;
          if ((hi_cnt_q < c_min_high) || (hi_cnt_q > c_max_high)) begin
            ev_wid = 1'b1;
          end
          if (s1_q) begin
            ev_gap   = 1'b1;
            state_d  = P1H;
            hi_cnt_d = c_cnt_one;
          end else begin
            state_d   = G21;
            gap_cnt_d = c_cnt_one;
          end
        end else begin
          hi_cnt_d = hi_inc;
          if (hi_inc > c_max_high) begin
            ev_wid = 1'b1;
          end
        end
      end

      G21: begin
        if (rise1) begin
          if (gap_cnt_q < c_min_gap) begin
            ev_gap = 1'b1;
          end
          period_done = 1'b1;
          state_d     = P1H;
          hi_cnt_d    = c_cnt_one;
        end else if (rise2) begin
          ev_ord   = 1'b1;
          state_d  = P2H;
          hi_cnt_d = c_cnt_one;
        end else begin
          gap_cnt_d = gap_inc;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ev_any = ev_ovl | ev_gap | ev_wid | ev_ord;

  // Sticky flags, period accounting and lock tracking.
  always_comb begin
    // A new event in the clearing cycle keeps its flag set.
    ovl_d        = (ovl_q & ~bus.clr_err) | ev_ovl;
    gap_d        = (gap_q & ~bus.clr_err) | ev_gap;
    wid_d        = (wid_q & ~bus.clr_err) | ev_wid;
    ord_d        = (ord_q & ~bus.clr_err) | ev_ord;
    period_cnt_d = period_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    locked_d     = locked_q;
    dirty_d      = dirty_q;

    if (ev_any) begin
      dirty_d    = 1'b1;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end

    // dirty_q marks an error since the last completion; an error in the
    // completing cycle itself also spoils the period.
    if (period_done) begin
      if (!ev_any && !dirty_q) begin
        period_cnt_d = period_cnt_q + 1'b1;
        if (lock_cnt_q < c_lock) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
        if (lock_cnt_d == c_lock) begin
          locked_d = 1'b1;
        end
      end
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge master) begin
    if (rst) begin
      meta1_q      <= 1'b0;
      meta2_q      <= 1'b0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      p1_q         <= 1'b0;
      p2_q         <= 1'b0;
      state_q      <= IDLE;
      hi_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      last_w1_q    <= '0;
      last_w2_q    <= '0;
      period_cnt_q <= '0;
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
      dirty_q      <= 1'b0;
      ovl_q        <= 1'b0;
      gap_q        <= 1'b0;
      wid_q        <= 1'b0;
      ord_q        <= 1'b0;
    end else begin
      meta1_q      <= bus.phi1;
      meta2_q      <= bus.phi2;
      s1_q         <= meta1_q;
      s2_q         <= meta2_q;
      p1_q         <= s1_q;
      p2_q         <= s2_q;
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_w1_q    <= last_w1_d;
      last_w2_q    <= last_w2_d;
      period_cnt_q <= period_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      locked_q     <= locked_d;
      dirty_q      <= dirty_d;
      ovl_q        <= ovl_d;
      gap_q        <= gap_d;
      wid_q        <= wid_d;
      ord_q        <= ord_d;
    end
  end

  assign bus.overlap_err = ovl_q;
  assign bus.gap_err     = gap_q;
  assign bus.width_err   = wid_q;
  assign bus.order_err   = ord_q;
  assign bus.locked      = locked_q;
  assign bus.period_cnt  = period_cnt_q;
  assign bus.last_w1     = last_w1_q;
  assign bus.last_w2     = last_w2_q;

endmodule
`default_nettype wire
